// File: rtl/led_step_timer.sv
// Timebase for the LED rotator: free-running pulses every LIMIT_k clocks, or one
// pulse per step-button rising edge while stopped. Counter and state exposed for debug.
module led_step_timer #(
  parameter int unsigned           NB_COUNTER = 32,
  parameter logic [NB_COUNTER-1:0] LIMIT_0    = NB_COUNTER'(2**23),
  parameter logic [NB_COUNTER-1:0] LIMIT_1    = NB_COUNTER'(2**24),
  parameter logic [NB_COUNTER-1:0] LIMIT_2    = NB_COUNTER'(2**25),
  parameter logic [NB_COUNTER-1:0] LIMIT_3    = NB_COUNTER'(2**26)
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [1:0]            i_sel,
  input  logic                  i_step,
  output logic                  o_valid,
  output logic [NB_COUNTER-1:0] o_count,
  output logic [1:0]            o_state
);

  // o_valid is a plain strobe with no back-pressure: the rotator consumes every
  // cycle it is high, and it is high for exactly one cycle per timing event.

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t                  state_q;
  logic [NB_COUNTER-1:0]   count_q;
  logic                    valid_q;
  logic [1:0]              sel_q;
  logic                    step_q;

  logic                    step_rise;
  logic                    sel_chg;
  logic [NB_COUNTER-1:0]   limit;
  logic [NB_COUNTER-1:0]   limit_m1;

  assign step_rise = i_step & ~step_q;
  assign sel_chg   = (i_sel != sel_q);

  always_comb begin
    limit = LIMIT_0;
    case (sel_q)
      2'd0:    limit = LIMIT_0;
      2'd1:    limit = LIMIT_1;
      2'd2:    limit = LIMIT_2;
      default: limit = LIMIT_3;
    endcase
    limit_m1 = limit - NB_COUNTER'(1);
  end

  always_ff @(posedge clock) begin
    // Input history is refreshed even in reset so no false step edge appears on release.
    sel_q  <= i_sel;
    step_q <= i_step;
    if (i_reset) begin
      state_q <= ST_STOP;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_STOP: begin
          count_q <= '0;
          valid_q <= 1'b0;
          if (i_enable)       state_q <= ST_RUN;
          else if (step_rise) state_q <= ST_STEP;
        end
        ST_RUN: begin
          if (!i_enable) begin
            count_q <= '0;
            valid_q <= 1'b0;
            state_q <= ST_STOP;
          end else if (sel_chg) begin
            // Restart the period from zero under the newly selected limit.
            count_q <= '0;
            valid_q <= 1'b0;
          end else if (count_q == limit_m1) begin
            count_q <= '0;
            valid_q <= 1'b1;
          end else begin
            count_q <= count_q + NB_COUNTER'(1);
            valid_q <= 1'b0;
          end
        end
        ST_STEP: begin
          count_q <= '0;
          valid_q <= 1'b1;
          state_q <= i_enable ? ST_RUN : ST_STOP;
        end
        default: begin
          count_q <= '0;
          valid_q <= 1'b0;
          state_q <= ST_STOP;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_led_step_timer.sv
// Bench for led_step_timer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an elapsed-time model.
module tb_led_step_timer;

  localparam int NB = 16;
  localparam int LIM [4] = '{4, 8, 3, 2};

  logic          clock;
  logic          i_reset;
  logic          i_enable;
  logic [1:0]    i_sel;
  logic          i_step;
  logic          o_valid;
  logic [NB-1:0] o_count;
  logic [1:0]    o_state;

  int total = 0;
  int bad   = 0;

  led_step_timer #(
    .NB_COUNTER(NB),
    .LIMIT_0   (NB'(4)),
    .LIMIT_1   (NB'(8)),
    .LIMIT_2   (NB'(3)),
    .LIMIT_3   (NB'(2))
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_sel   (i_sel),
    .i_step  (i_step),
    .o_valid (o_valid),
    .o_count (o_count),
    .o_state (o_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: mode is stopped / running / single-step cycle, elapsed is
  // the number of clocks spent in the current period.
  int       m_mode;    // 0 stopped, 1 running, 2 step cycle
  int       m_elapsed;
  bit       m_pulse;
  bit [1:0] m_prev_sel;
  bit       m_prev_step;
  bit       m_ok = 1'b0;

  always @(posedge clock) begin
    bit rise, chg;
    int period;
    if (i_reset) begin
      m_mode = 0; m_elapsed = 0; m_pulse = 1'b0;
    end else begin
      rise   = i_step && !m_prev_step;
      chg    = (i_sel != m_prev_sel);
      period = LIM[m_prev_sel];
      if (m_mode == 0) begin
        m_pulse = 1'b0; m_elapsed = 0;
        if (i_enable) m_mode = 1;
        else if (rise) m_mode = 2;
      end else if (m_mode == 1) begin
        m_pulse = 1'b0;
        if (!i_enable) begin
          m_mode = 0; m_elapsed = 0;
        end else if (chg) begin
          m_elapsed = 0;
        end else begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == period) begin
            m_elapsed = 0; m_pulse = 1'b1;
          end
        end
      end else begin
        m_pulse = 1'b1; m_elapsed = 0;
        m_mode = i_enable ? 1 : 0;
      end
    end
    m_prev_sel  = i_sel;
    m_prev_step = i_step;
    m_ok = 1'b1;
  end

  // scoreboard: every cycle against the model
  always @(negedge clock) begin
    logic [31:0] exp_q[$];
    if (m_ok) begin
      exp_q.push_back(32'(m_pulse));
      exp_q.push_back(32'(m_elapsed));
      exp_q.push_back(m_mode == 2 ? 32'd2 : (m_mode == 1 ? 32'd1 : 32'd0));
      check("model_valid", 32'(o_valid), exp_q.pop_front());
      check("model_count", 32'(o_count), exp_q.pop_front());
      check("model_state", 32'(o_state), exp_q.pop_front());
    end
  end

  initial begin
    int pulses, visits, first, last;
    i_reset = 1'b1; i_enable = 1'b1; i_sel = 2'd0; i_step = 1'b0;

    // Reset priority over enable
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", 32'(o_valid), 0);
      check("rst_count", 32'(o_count), 0);
      check("rst_state", 32'(o_state), 0);
    end
    i_reset = 1'b0;
    tick();
    check("rst_release_state", 32'(o_state), 1);
    check("rst_release_count", 32'(o_count), 0);

    // Free run, limit 4: counts 1,2,3,0 with a pulse on each 0
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_valid) pulses++;
      if (i <= 5) begin
        check("run_count", 32'(o_count), 32'(i % 4));
        check("run_valid", 32'(o_valid), (i % 4 == 0) ? 1 : 0);
      end
    end
    check("run_pulses_40", 32'(pulses), 10);

    // Rate change at count 2
    tick(); tick();
    check("chg_pre_count", 32'(o_count), 2);
    i_sel = 2'd1;
    tick();
    check("chg_clear_count", 32'(o_count), 0);
    check("chg_clear_valid", 32'(o_valid), 0);
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      tick();
      if (o_valid) first = i;
    end
    check("chg_first_pulse", 32'(first), 8);

    // Stop mid-count at 3 of limit 4
    i_sel = 2'd0;
    tick();
    for (int i = 0; i < 10 && o_count != 3; i++) tick();
    check("stop_pre_count", 32'(o_count), 3);
    i_enable = 1'b0;
    tick();
    check("stop_valid", 32'(o_valid), 0);
    check("stop_count", 32'(o_count), 0);
    check("stop_state", 32'(o_state), 0);
    tick();
    check("stop_hold_valid", 32'(o_valid), 0);
    i_enable = 1'b1;
    tick();
    check("reen_state", 32'(o_state), 1);
    first = -1;
    for (int i = 1; i <= 10 && first < 0; i++) begin
      tick();
      if (o_valid) first = i;
    end
    check("reen_first_pulse", 32'(first), 4);

    // Single step: one pulse, two clocks after the rising edge is sampled
    i_enable = 1'b0;
    tick();
    pulses = 0; visits = 0; first = -1;
    i_step = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (o_state == 2'b10) visits++;
      if (o_valid) begin pulses++; if (first < 0) first = i; end
    end
    i_step = 1'b0;
    for (int i = 6; i <= 7; i++) begin
      tick();
      if (o_valid) pulses++;
    end
    check("step_pulses", 32'(pulses), 1);
    check("step_visits", 32'(visits), 1);
    check("step_pulse_at", 32'(first), 2);

    // Step toggling while running does not disturb spacing
    i_enable = 1'b1;
    tick();
    pulses = 0; last = 0;
    for (int i = 1; i <= 24; i++) begin
      i_step = 1'($urandom_range(0, 1));
      tick();
      if (o_valid) begin
        pulses++;
        check("runstep_spacing", 32'(i - last), 4);
        last = i;
      end
    end
    check("runstep_pulses", 32'(pulses), 6);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      i_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 29) == 0) i_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0)  i_step = ~i_step;
      tick();
    end
    i_reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_step_timer.md
Name: led_step_timer

Overview:
- Timebase that produces the one-cycle i_valid strobe consumed by the LED rotator. It sits between the board switches/buttons and the rotator.
- Free-running mode: emits one pulse every LIMIT_k clocks, where LIMIT_k is selected by switches.
- Stopped mode: a button rising edge emits exactly one pulse (single-step).
- Exposes its counter and state for ILA/VIO debug.

Parameters:
- NB_COUNTER, 32, counter width in bits.
- LIMIT_0, 2**23, period in clocks for sel=0. Every LIMIT_k must satisfy 2 <= LIMIT_k < 2**NB_COUNTER.
- LIMIT_1, 2**24, period in clocks for sel=1.
- LIMIT_2, 2**25, period in clocks for sel=2.
- LIMIT_3, 2**26, period in clocks for sel=3.

Ports:
- clock  input  1  system clock; all logic on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_enable  input  1  level; 1 = free-run, 0 = stopped.
- i_sel  input  2  period select.
- i_step  input  1  single-step button, already debounced and synchronous.
- o_valid  output  1  one-cycle strobe to the rotator.
- o_count  output  NB_COUNTER  current counter value.
- o_state  output  2  00 STOP, 01 RUN, 10 STEP.

Behaviour:
- Reset: i_reset=1 sampled at posedge sets the following on the next cycle, regardless of other inputs and including mid-count:
  - state=STOP, count=0, o_valid=0
  - sel_q=i_sel, step_q=i_step (no false step edge out of reset).
- Registered inputs:
  - sel_q <= i_sel every cycle.
  - step_q <= i_step every cycle.
  - step_rise = i_step & ~step_q.
  - sel_chg = (i_sel != sel_q).
  - limit = LIMIT_[sel_q].
- o_valid is a register. It is high for exactly one cycle per event and never high on two consecutive cycles except at RUN with limit period.
- STOP:
  - count held at 0, o_valid=0.
  - i_enable=1 -> RUN.
  - else step_rise=1 -> STEP.
- RUN:
  - If i_enable=0: count<=0, o_valid<=0, -> STOP. An expiry in the same cycle is dropped.
  - Else if sel_chg: count<=0, o_valid<=0. The period restarts with the new limit from count 0.
  - Else if count == limit-1: count<=0, o_valid<=1.
  - Else: count<=count+1, o_valid<=0.
  - Period: exactly limit clocks between pulses. The first pulse occurs on the limit-th cycle after entering RUN with count=0.
  - step_rise is ignored in RUN.
- STEP (lasts one cycle):
  - o_valid<=1 for the following cycle, count stays 0.
  - Next state: RUN if i_enable=1, else STOP.
  - step_rise during STEP is ignored; a new step needs i_step to drop and rise again.
- Counter compare uses ==; count never exceeds limit-1 because sel_chg clears it. The counter never wraps at 2**NB_COUNTER.
- o_state and o_count are driven directly from registers.

Test Plan:
- Reset priority: hold i_reset=1 with i_enable=1 for 3 cycles -> o_valid=0, o_count=0, o_state=00; release -> state 01 next cycle.
- Free-run period: LIMIT_0=4, i_sel=0, i_enable=1 -> o_valid pulses once every 4 clocks; o_count cycles 0,1,2,3,0; 10 pulses in 40 clocks.
- Rate change mid-count: LIMIT_1=8, at count=2 switch i_sel 0->1 -> count cleared; next pulse exactly 8 clocks after the clear cycle; no pulse emitted at the old boundary.
- Single-step: i_enable=0, pulse i_step high for 5 cycles -> exactly one o_valid cycle 2 clocks after the rising edge and o_state visits 10 once; holding i_step high produces no further pulse.
- Stop mid-count: in RUN at count=3 of limit 4, drop i_enable -> o_valid stays 0, o_count=0, state 00; re-enable -> first pulse 4 clocks later.
- Step in RUN ignored: i_enable=1, toggle i_step -> pulse spacing unchanged at 4 clocks.
